// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR counter block: CSR addresses,
// the read-modify-write op encoding and the counter-inhibit bit layout.
package csr_pkg;

  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_CNT_BASE      = 12'hB00;
  localparam logic [11:0] CSR_CNTH_BASE     = 12'hB80;

  typedef enum logic [1:0] {
    CSR_READ = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_t;

  localparam int INH_CY       = 0;
  localparam int INH_IR       = 2;
  localparam int INH_HPM_BASE = 3;
  localparam int CNT_SLOTS    = 32;

  // Slots that hold a real counter; the same bits are the writable inhibit bits.
  function automatic logic [CNT_SLOTS-1:0] cnt_map(input int num_hpm);
    logic [CNT_SLOTS-1:0] map;
    map = '0;
    map[INH_CY] = 1'b1;
    map[INH_IR] = 1'b1;
    for (int i = 0; i < num_hpm; i++) begin
      map[INH_HPM_BASE + i] = 1'b1;
    end
    return map;
  endfunction

endpackage

// File: rtl/csr_counters_if.sv
// CSR request/response bus between the execute stage and the CSR counter block.
interface csr_counters_if #(
  parameter int XLEN = 32
);

  logic            req_valid;
  logic [1:0]      req_op;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [XLEN-1:0] rdata;
  logic            illegal;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  rdata, illegal
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output rdata, illegal
  );

endinterface

// File: rtl/csr_counter.sv
// One CNT_WIDTH-bit performance counter; a write to either half replaces that
// half only and suppresses the increment for that cycle.
module csr_counter #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 inhibit,
  input  logic                 wen_lo,
  input  logic                 wen_hi,
  input  logic [XLEN-1:0]      wdata,
  output logic [CNT_WIDTH-1:0] value
);

  localparam int HI_W = CNT_WIDTH - XLEN;

  logic [CNT_WIDTH-1:0] value_r;
  logic [CNT_WIDTH-1:0] next_s;

  // Next value: half-write beats increment, no carry across halves on a write.
  always_comb begin
    next_s = value_r;
    if (wen_lo) begin
      next_s[XLEN-1:0] = wdata;
    end else if (wen_hi) begin
      next_s[CNT_WIDTH-1:XLEN] = wdata[HI_W-1:0];
    end else if (inc && !inhibit) begin
      next_s = value_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      next_s = value_r;
    end
  end

  // Counter state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_r <= '0;
    end else begin
      value_r <= next_s;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/csr_counters.sv
// Machine-mode CSR block: ID constants, mcountinhibit and a bank of
// mcycle/minstret/mhpmcounter counters behind an atomic RMW CSR port.
module csr_counters
  import csr_pkg::*;
#(
  parameter int              XLEN          = 32,
  parameter int              CNT_WIDTH     = 64,
  parameter int              NUM_HPM       = 4,
  parameter logic [XLEN-1:0] MISA_VAL      = 32'h4000_0010,
  parameter logic [XLEN-1:0] MVENDORID_VAL = 32'h6265_6B61,
  parameter logic [XLEN-1:0] MARCHID_VAL   = 32'h0531_8008
) (
  input  logic               clock,
  input  logic               reset,
  csr_counters_if.slave      bus,
  input  logic               inst_retired,
  input  logic [NUM_HPM-1:0] hpm_event
);

  localparam logic [CNT_SLOTS-1:0] CNT_MAP      = cnt_map(NUM_HPM);
  localparam logic [XLEN-1:0]      INHIBIT_MASK = XLEN'(CNT_MAP);

  logic [CNT_WIDTH-1:0] cnt_value_s [CNT_SLOTS];
  logic [XLEN-1:0]      mcountinhibit_r;
  csr_op_t              op_s;
  logic                 is_lo_s;
  logic                 is_hi_s;
  logic [4:0]           idx_s;
  logic                 hit_s;
  logic [XLEN-1:0]      old_s;
  logic [XLEN-1:0]      new_s;
  logic                 wr_attempt_s;
  logic                 illegal_s;
  logic                 wen_s;

  assign op_s    = csr_op_t'(bus.req_op);
  assign is_lo_s = (bus.req_addr[11:5] == CSR_CNT_BASE[11:5]);
  assign is_hi_s = (bus.req_addr[11:5] == CSR_CNTH_BASE[11:5]);
  assign idx_s   = bus.req_addr[4:0];

  // Address decode and pre-write read value.
  always_comb begin
    hit_s = 1'b0;
    old_s = '0;
    case (bus.req_addr)
      CSR_MISA: begin
        hit_s = 1'b1;
        old_s = MISA_VAL;
      end
      CSR_MVENDORID: begin
        hit_s = 1'b1;
        old_s = MVENDORID_VAL;
      end
      CSR_MARCHID: begin
        hit_s = 1'b1;
        old_s = MARCHID_VAL;
      end
      CSR_MCOUNTINHIBIT: begin
        hit_s = 1'b1;
        old_s = mcountinhibit_r;
      end
      default: begin
        if ((is_lo_s || is_hi_s) && CNT_MAP[idx_s]) begin
          hit_s = 1'b1;
          if (is_hi_s) begin
            old_s[CNT_WIDTH-XLEN-1:0] = cnt_value_s[idx_s][CNT_WIDTH-1:XLEN];
          end else begin
            old_s = cnt_value_s[idx_s][XLEN-1:0];
          end
        end else begin
          hit_s = 1'b0;
          old_s = '0;
        end
      end
    endcase
  end

  // Op merge, fault detection and response drive.
  always_comb begin
    wr_attempt_s = (op_s == CSR_RW) ||
                   (((op_s == CSR_RS) || (op_s == CSR_RC)) && (|bus.req_wdata));
    case (op_s)
      CSR_RW:  new_s = bus.req_wdata;
      CSR_RS:  new_s = old_s | bus.req_wdata;
      CSR_RC:  new_s = old_s & ~bus.req_wdata;
      default: new_s = old_s;
    endcase
    illegal_s = bus.req_valid &&
                (!hit_s || (wr_attempt_s && (bus.req_addr[11:10] == 2'b11)));
    wen_s     = bus.req_valid && !illegal_s && wr_attempt_s;
    if (bus.req_valid) begin
      bus.rdata = old_s;
    end else begin
      bus.rdata = '0;
    end
    bus.illegal = illegal_s;
  end

  // Counter-inhibit register; unimplemented bits never stick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcountinhibit_r <= '0;
    end else if (wen_s && (bus.req_addr == CSR_MCOUNTINHIBIT)) begin
      mcountinhibit_r <= new_s & INHIBIT_MASK;
    end else begin
      mcountinhibit_r <= mcountinhibit_r;
    end
  end

  for (genvar n = 0; n < CNT_SLOTS; n++) begin : g_cnt
    if (CNT_MAP[n]) begin : g_on
      logic inc_s;
      if (n == INH_CY) begin : g_cy
        assign inc_s = 1'b1;
      end else if (n == INH_IR) begin : g_ir
        assign inc_s = inst_retired;
      end else begin : g_hpm
        assign inc_s = hpm_event[n-INH_HPM_BASE];
      end

      csr_counter #(
        .XLEN      (XLEN),
        .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
        .clock   (clock),
        .reset   (reset),
        .inc     (inc_s),
        .inhibit (mcountinhibit_r[n]),
        .wen_lo  (wen_s && is_lo_s && (idx_s == 5'(n))),
        .wen_hi  (wen_s && is_hi_s && (idx_s == 5'(n))),
        .wdata   (new_s),
        .value   (cnt_value_s[n])
      );
    end else begin : g_off
      assign cnt_value_s[n] = '0;
    end
  end

endmodule

// File: tb/tb_csr_counters.sv
// Scoreboard bench for csr_counters: directed scenarios then random traffic,
// checked against a behavioural model of the CSR file and counters.
module tb_csr_counters;

  localparam int XLEN      = 32;
  localparam int CNT_WIDTH = 64;
  localparam int NUM_HPM   = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               inst_retired;
  logic [NUM_HPM-1:0] hpm_event;

  csr_counters_if #(.XLEN(XLEN)) bus ();

  csr_counters #(
    .XLEN      (XLEN),
    .CNT_WIDTH (CNT_WIDTH),
    .NUM_HPM   (NUM_HPM)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .inst_retired (inst_retired),
    .hpm_event    (hpm_event)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        illegal;
    string       tag;
  } exp_t;

  exp_t        exp_q [$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] cnt_m [32];
  logic [31:0] inh_m;
  bit          in_reset;

  localparam logic [31:0] MVEND    = "beka";
  localparam logic [31:0] INH_WMSK = 32'h0000_007D;

  function automatic bit slot_exists(input int n);
    return (n == 0) || (n == 2) || (n >= 3 && n < 3 + NUM_HPM);
  endfunction

  function automatic void model_read(input logic [11:0] a, output logic [31:0] val,
                                     output bit mapped);
    int n;
    mapped = 0;
    val    = 32'h0;
    n      = int'(a & 12'h01F);
    if (a == 12'h301)      begin mapped = 1; val = 32'h4000_0010; end
    else if (a == 12'hF11) begin mapped = 1; val = MVEND; end
    else if (a == 12'hF12) begin mapped = 1; val = 32'h0531_8008; end
    else if (a == 12'h320) begin mapped = 1; val = inh_m; end
    else if ((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F)) begin
      if (slot_exists(n)) begin
        mapped = 1;
        val = (a >= 12'hB80) ? cnt_m[n][63:32] : cnt_m[n][31:0];
      end
    end
  endfunction

  // Drive one cycle of stimulus, queue its expected response, then advance the model.
  task automatic step(input bit v, input int op, input logic [11:0] a,
                      input logic [31:0] wd, input bit ret, input logic [3:0] ev);
    logic [31:0] old_v, new_v;
    bit mapped, wa, ill, do_w, is_cnt;
    int idx;
    exp_t e;
    bus.req_valid = v;
    bus.req_op    = op[1:0];
    bus.req_addr  = a;
    bus.req_wdata = wd;
    inst_retired  = ret;
    hpm_event     = ev;
    model_read(a, old_v, mapped);
    wa      = (op == 1) || ((op >= 2) && (wd != 32'h0));
    ill     = v && (!mapped || (wa && a >= 12'hC00));
    e.rdata = (v && mapped) ? old_v : 32'h0;
    e.illegal = ill;
    e.tag   = $sformatf("v%0d_op%0d_%h", v, op, a);
    exp_q.push_back(e);
    new_v  = (op == 1) ? wd : (op == 2) ? (old_v | wd) : (old_v & ~wd);
    do_w   = v && !ill && wa;
    is_cnt = (a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F);
    idx    = int'(a & 12'h01F);
    @(posedge clock);
    if (!in_reset) begin
      for (int n = 0; n < 32; n++) begin
        if (slot_exists(n)) begin
          bit inc;
          inc = (n == 0) ? 1'b1 : (n == 2) ? ret : ev[n-3];
          if (do_w && is_cnt && n == idx) begin
            if (a >= 12'hB80) cnt_m[n] = {new_v, cnt_m[n][31:0]};
            else              cnt_m[n] = {cnt_m[n][63:32], new_v};
          end else if (inc && !inh_m[n]) begin
            cnt_m[n] = cnt_m[n] + 64'd1;
          end
        end
      end
      if (do_w && a == 12'h320) inh_m = new_v & INH_WMSK;
    end
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 12'h000, 32'h0, 0, 4'h0);
  endtask

  task automatic rd(input logic [11:0] a, input bit ret);
    step(1, 0, a, 32'h0, ret, 4'h0);
  endtask

  // Monitor: compare the DUT response against the oldest queued expectation.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bus.rdata !== e.rdata) begin
        errors++;
        $display("FAIL rdata %s: got %h expected %h", e.tag, bus.rdata, e.rdata);
      end
      checks++;
      if (bus.illegal !== e.illegal) begin
        errors++;
        $display("FAIL illegal %s: got %b expected %b", e.tag, bus.illegal, e.illegal);
      end
    end
  end

  logic [11:0] addr_tab [16] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83,
                                 12'hB06, 12'hB86, 12'hB07, 12'hB01, 12'h320, 12'h301,
                                 12'hF11, 12'hF12, 12'h300, 12'hC00};

  initial begin
    int wait_cnt;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_addr  = 12'h000;
    bus.req_wdata = 32'h0;
    inst_retired  = 1'b0;
    hpm_event     = 4'h0;
    in_reset      = 1;
    for (int n = 0; n < 32; n++) cnt_m[n] = 64'h0;
    inh_m = 32'h0;
    @(posedge clock);
    #1;
    rd(12'hB00, 0);
    idle(2);
    reset    = 1'b0;
    in_reset = 0;

    idle(10);
    rd(12'hB00, 0);
    rd(12'hB80, 0);

    step(1, 1, 12'hB00, 32'hFFFF_FFFF, 0, 4'h0);
    step(1, 1, 12'hB80, 32'h0, 0, 4'h0);
    rd(12'hB00, 0);
    rd(12'hB80, 0);
    rd(12'hB00, 0);

    step(1, 2, 12'h320, 32'h5, 1, 4'h0);
    rd(12'hB00, 1);
    rd(12'hB00, 1);
    rd(12'hB02, 1);
    step(1, 3, 12'h320, 32'h1, 1, 4'h0);
    rd(12'hB00, 1);
    rd(12'hB02, 1);
    rd(12'hB00, 1);
    step(1, 3, 12'h320, 32'h4, 1, 4'h0);
    step(1, 1, 12'hB02, 32'h100, 1, 4'h0);
    rd(12'hB02, 0);

    for (int i = 0; i < 3; i++) begin
      step(0, 0, 12'h000, 32'h0, 0, 4'h1);
      idle(1);
    end
    rd(12'hB03, 0);
    rd(12'hB07, 0);
    rd(12'hB06, 0);

    step(1, 1, 12'hF11, 32'h1234_5678, 0, 4'h0);
    step(1, 2, 12'hF11, 32'h0, 0, 4'h0);
    step(1, 3, 12'h320, 32'h2, 0, 4'h0);
    rd(12'h320, 0);
    step(1, 2, 12'h320, 32'hFFFF_FFFF, 0, 4'h0);
    rd(12'h320, 0);
    step(1, 1, 12'h320, 32'h0, 0, 4'h0);
    step(1, 1, 12'hB83, 32'hFFFF_FFFF, 0, 4'h0);
    step(1, 1, 12'hB03, 32'hFFFF_FFFF, 0, 4'h1);
    step(0, 0, 12'h000, 32'h0, 0, 4'h1);
    rd(12'hB03, 0);
    rd(12'hB83, 0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] wd;
      int sel;
      sel = int'($urandom_range(0, 3));
      wd  = (sel == 0) ? 32'h0 : (sel == 1) ? (32'hFFFF_FFFF - $urandom_range(0, 3)) : $urandom;
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
           addr_tab[$urandom_range(0, 15)], wd, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)));
    end
    idle(1);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clock);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
